// File: rtl/setup_hold_pkg.sv
// rtl/setup_hold_pkg.sv - shared types and defaults for the setup/hold monitor
package setup_hold_pkg;

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        HOLD_WIN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        EV_RISE = 2'd0,
        EV_FALL = 2'd1,
        EV_ANY  = 2'd2
    } ev_sel_e;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/setup_hold_monitor_sync_edge.sv
// rtl/setup_hold_monitor_sync_edge.sv - synchronizer, prev flop and selectable change pulse
module sync_edge
    import setup_hold_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    async_in,
    input  ev_sel_e mode,
    output logic    pulse
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise, fall, change;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = async_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];

        rise   = sync_q[STAGES-1] & ~prev_q;
        fall   = ~sync_q[STAGES-1] & prev_q;
        change = sync_q[STAGES-1] ^ prev_q;

        // mode only selects among pulses already derived from sync/prev, so flipping it cannot fake an edge
        case (mode)
            EV_RISE: pulse = rise;
            EV_FALL: pulse = fall;
            default: pulse = change;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/setup_hold_monitor.sv
// rtl/setup_hold_monitor.sv - judges setup/hold gaps between d transitions and dut_clk edges
module setup_hold_monitor
    import setup_hold_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dut_clk,
    input  logic             d,
    input  logic             edge_sel,
    input  logic [CNT_W-1:0] setup_ticks,
    input  logic [CNT_W-1:0] hold_ticks,
    output logic             setup_viol,
    output logic             hold_viol,
    output logic [CNT_W-1:0] viol_count,
    output logic [CNT_W-1:0] last_gap
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = 1;
    localparam logic [CNT_W:0]   ONE_W    = 1;

    logic    d_trans, clk_edge;
    ev_sel_e clk_mode;

    assign clk_mode = edge_sel ? EV_FALL : EV_RISE;

    sync_edge #(.STAGES(SYNC_STAGES)) u_d_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (d),
        .mode     (EV_ANY),
        .pulse    (d_trans)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (dut_clk),
        .mode     (clk_mode),
        .pulse    (clk_edge)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] d_age_q, d_age_d;
    logic [CNT_W-1:0] edge_age_q, edge_age_d;
    logic [CNT_W-1:0] viol_count_q, viol_count_d;
    logic [CNT_W-1:0] last_gap_q, last_gap_d;
    logic             setup_viol_q, setup_viol_d;
    logic             hold_viol_q, hold_viol_d;
    logic [CNT_W-1:0] gap;
    logic [CNT_W:0]   sum;

    always_comb begin
        // gap is the age as of this cycle, so a transition coincident with the edge reads 0
        gap     = d_trans ? '0 : ((d_age_q == ALL_ONES) ? ALL_ONES : d_age_q + ONE);
        d_age_d = gap;

        setup_viol_d = clk_edge && (gap < setup_ticks);
        hold_viol_d  = (state_q == HOLD_WIN) && d_trans && !clk_edge
                       && (edge_age_q < hold_ticks);
        last_gap_d   = clk_edge ? gap : last_gap_q;

        state_d    = state_q;
        edge_age_d = edge_age_q;
        if (clk_edge) begin
            if ((state_q == HOLD_WIN) || (hold_ticks != '0)) begin
                state_d    = HOLD_WIN;
                edge_age_d = '0;
            end
        end else if (state_q == HOLD_WIN) begin
            // >= rather than == so a threshold lowered mid-window still closes it
            if (({1'b0, edge_age_q} + ONE_W) >= {1'b0, hold_ticks}) begin
                state_d    = WAIT_EDGE;
                edge_age_d = '0;
            end else begin
                edge_age_d = edge_age_q + ONE;
            end
        end

        sum = {1'b0, viol_count_q} + {{CNT_W{1'b0}}, setup_viol_d}
              + {{CNT_W{1'b0}}, hold_viol_d};
        viol_count_d = sum[CNT_W] ? ALL_ONES : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_EDGE;
            d_age_q      <= ALL_ONES;
            edge_age_q   <= '0;
            viol_count_q <= '0;
            last_gap_q   <= '0;
            setup_viol_q <= 1'b0;
            hold_viol_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_age_q      <= d_age_d;
            edge_age_q   <= edge_age_d;
            viol_count_q <= viol_count_d;
            last_gap_q   <= last_gap_d;
            setup_viol_q <= setup_viol_d;
            hold_viol_q  <= hold_viol_d;
        end
    end

    assign setup_viol = setup_viol_q;
    assign hold_viol  = hold_viol_q;
    assign viol_count = viol_count_q;
    assign last_gap   = last_gap_q;

endmodule

// File: tb/tb_setup_hold_monitor.sv
// tb/tb_setup_hold_monitor.sv - scoreboard bench for setup_hold_monitor
module tb_setup_hold_monitor;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dut_clk = 1'b0;
    logic          d = 1'b0;
    logic          edge_sel = 1'b0;
    logic [CW-1:0] setup_ticks = 8'd4;
    logic [CW-1:0] hold_ticks = 8'd3;
    logic          setup_viol, hold_viol;
    logic [CW-1:0] viol_count, last_gap;

    setup_hold_monitor #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .dut_clk     (dut_clk),
        .d           (d),
        .edge_sel    (edge_sel),
        .setup_ticks (setup_ticks),
        .hold_ticks  (hold_ticks),
        .setup_viol  (setup_viol),
        .hold_viol   (hold_viol),
        .viol_count  (viol_count),
        .last_gap    (last_gap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tgt;
        bit s;
        bit h;
        int gap;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    // reference: event times in sampled-cycle units, outputs appear two posedges after sampling
    logic m_prev_d = 1'b0, m_prev_c = 1'b0;
    int   m_last_d = -1, m_last_e = -1, m_last_h = 0, m_cnt = 0, m_gap = 0;

    task automatic model_step(input int k, input logic nd, input logic nc, input logic nr);
        bit dt, ce, s, h;
        int g;
        if (nr) begin
            m_prev_d = 1'b0; m_prev_c = 1'b0;
            m_last_d = -1; m_last_e = -1; m_last_h = 0; m_cnt = 0; m_gap = 0;
            while (q.size() > 0 && q[$].tgt >= k) void'(q.pop_back());
            return;
        end
        dt = (nd != m_prev_d);
        ce = edge_sel ? (m_prev_c && !nc) : (!m_prev_c && nc);
        m_prev_d = nd;
        m_prev_c = nc;
        if (dt) m_last_d = k;
        s = 0;
        h = 0;
        if (ce) begin
            g = (m_last_d < 0 || k - m_last_d > 255) ? 255 : k - m_last_d;
            m_gap = g;
            s = (g < int'(setup_ticks));
            m_last_e = k;
            m_last_h = int'(hold_ticks);
        end else if (dt && m_last_e >= 0 && (k - m_last_e) <= m_last_h) begin
            h = 1;
        end
        m_cnt = m_cnt + int'(s) + int'(h);
        if (m_cnt > 255) m_cnt = 255;
        if (s || h) q.push_back('{k + 2, s, h, m_gap, m_cnt});
    endtask

    task automatic step(input logic nd, input logic nc, input logic nr);
        @(negedge clk);
        d = nd;
        dut_clk = nc;
        rst = nr;
        model_step(cyc + 1, nd, nc, nr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(d, dut_clk, 1'b0);
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].tgt == cyc) begin
            e = q.pop_front();
            checks++;
            if (setup_viol !== e.s || hold_viol !== e.h ||
                last_gap !== 8'(e.gap) || viol_count !== 8'(e.cnt)) begin
                failures++;
                $display("FAIL event@%0d: got s=%b h=%b gap=%0d cnt=%0d expected s=%b h=%b gap=%0d cnt=%0d",
                         cyc, setup_viol, hold_viol, last_gap, viol_count, e.s, e.h, e.gap, e.cnt);
            end
        end else if (!rst && (setup_viol !== 1'b0 || hold_viol !== 1'b0)) begin
            checks++;
            failures++;
            $display("FAIL spurious@%0d: got s=%b h=%b expected no pulse", cyc, setup_viol, hold_viol);
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("reset_setup_viol", int'(setup_viol), 0);
        check_eq("reset_hold_viol", int'(hold_viol), 0);
        check_eq("reset_viol_count", int'(viol_count), 0);
        check_eq("reset_last_gap", int'(last_gap), 0);
        idle(4);

        // legal: d 8 cycles before the rise, stable 5 after
        step(1'b1, 1'b0, 1'b0); idle(7); step(1'b1, 1'b1, 1'b0); idle(5);
        step(1'b1, 1'b0, 1'b0); idle(8);
        check_eq("legal_last_gap", int'(last_gap), 8);
        check_eq("legal_count", int'(viol_count), 0);

        // setup violation: gap 2
        step(1'b0, 1'b0, 1'b0); idle(1); step(1'b0, 1'b1, 1'b0); idle(8);
        check_eq("setup_last_gap", int'(last_gap), 2);
        check_eq("setup_count", int'(viol_count), 1);
        step(1'b0, 1'b0, 1'b0); idle(8);

        // hold violation: d moves 1 cycle after a rise with gap 6
        step(1'b1, 1'b0, 1'b0); idle(5); step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); idle(8);
        check_eq("hold_last_gap", int'(last_gap), 6);
        check_eq("hold_count", int'(viol_count), 2);
        step(1'b0, 1'b0, 1'b0); idle(8);

        // coincident transition and rise
        step(1'b1, 1'b1, 1'b0); idle(8);
        check_eq("coinc_last_gap", int'(last_gap), 0);
        check_eq("coinc_count", int'(viol_count), 3);
        step(1'b1, 1'b0, 1'b0); idle(8);

        // falling-edge checking, unchecked rise, then two falls 2 cycles apart
        edge_sel = 1'b1;
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0); idle(260);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); idle(8);
        check_eq("fall_last_gap", int'(last_gap), 255);
        check_eq("fall_count", int'(viol_count), 3);
        edge_sel = 1'b0;

        // saturation
        for (int i = 0; i < 260; i++) begin
            step(~d, 1'b1, 1'b0);
            step(d, 1'b0, 1'b0);
        end
        idle(8);
        check_eq("sat_count", int'(viol_count), 255);

        // reset mid hold window, then a d toggle right after
        step(d, 1'b1, 1'b0); step(d, 1'b0, 1'b0); step(d, 1'b0, 1'b0);
        step(d, 1'b0, 1'b1);
        step(~d, 1'b0, 1'b0);
        check_eq("rst_setup_viol", int'(setup_viol), 0);
        check_eq("rst_hold_viol", int'(hold_viol), 0);
        check_eq("rst_viol_count", int'(viol_count), 0);
        check_eq("rst_last_gap", int'(last_gap), 0);
        idle(8);
        check_eq("rst_after_count", int'(viol_count), 0);

        // randomized bursts; thresholds change only while the pipeline is quiet
        for (int b = 0; b < 20; b++) begin
            setup_ticks = 8'($urandom_range(0, 8));
            hold_ticks  = 8'($urandom_range(0, 5));
            edge_sel    = 1'($urandom_range(0, 1));
            repeat (40) step(d ^ ($urandom_range(0, 3) == 0), dut_clk ^ ($urandom_range(0, 3) == 0), 1'b0);
            idle(8);
            check_eq("rand_last_gap", int'(last_gap), m_gap);
            check_eq("rand_count", int'(viol_count), m_cnt);
        end

        idle(4);
        check_eq("pending_events", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
